frame_load_ctrl: RTL and testbench
==================================

FRAME_LOAD_CTRL -- requirements
Module: frame_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 307200; the number of bytes per frame (640x480, 8-bit pixels).
REQ-002 SHALL have parameter ADDR_W, default 19; the frame-buffer address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 5000000; the allowed idle cycles between bytes (100 ms at 50 MHz).
REQ-004 SHALL have port clk, input, 1: single system clock (50 MHz).
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port rx_data, input, 8: received UART byte.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle pulse, rx_data valid.
REQ-008 SHALL have port rx_ferr, input, 1: stop-bit error, qualified by rx_valid.
REQ-009 SHALL have port clear_req, input, 1: one-cycle request to fill the buffer.
REQ-010 SHALL have port fill_value, input, 8: byte written during clear.
REQ-011 SHALL have port wr_en, output, 1: BRAM write enable.
REQ-012 SHALL have port wr_addr, output, ADDR_W: BRAM write address.
REQ-013 SHALL have port wr_data, output, 8: BRAM write data.
REQ-014 SHALL have port busy, output, 1: high in HDR, LOAD and CLEAR.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse when a full frame is written.
REQ-016 SHALL have port clear_done, output, 1: one-cycle pulse when clear completes.
REQ-017 SHALL have port err_abort, output, 1: one-cycle pulse when a load is aborted.
REQ-018 SHALL have port frame_count, output, 8: count of completed frames, wrapping from 255 to 0.
REQ-019 SHALL have port state, output, 2: debug encoding, IDLE=0, HDR=1, LOAD=2, CLEAR=3.

Function
REQ-020 SHALL register all outputs; wr_en/wr_addr/wr_data SHALL appear exactly 1 cycle after the accepted rx_valid, or 1 cycle after the CLEAR counter update.
REQ-021 In IDLE, rx_valid with rx_data=0xAA and rx_ferr=0 SHALL move to HDR; all other bytes SHALL be discarded with no write.
REQ-022 In HDR, byte 0x55 SHALL move to LOAD and zero the pixel counter; byte 0xAA SHALL stay in HDR; any other byte, or any byte with rx_ferr=1, SHALL return to IDLE with no err_abort.
REQ-023 In LOAD, each rx_valid with rx_ferr=0 SHALL produce one write with wr_addr=pixel counter and wr_data=rx_data, then increment the counter.
REQ-024 The write at address NUM_PIXELS-1 SHALL be accompanied, in the same cycle, by frame_done=1 and a frame_count increment, followed by return to IDLE.
REQ-025 In LOAD, rx_valid with rx_ferr=1 SHALL drop the byte, pulse err_abort and return to IDLE; bytes already written SHALL remain, and frame_count SHALL be unchanged.
REQ-026 In HDR or LOAD, TIMEOUT_CYC consecutive cycles without rx_valid SHALL pulse err_abort and return to IDLE; the idle counter SHALL reset on every rx_valid and on every state entry.
REQ-027 clear_req in IDLE SHALL enter CLEAR and write fill_value to addresses 0..NUM_PIXELS-1, one per cycle, with no gaps.
REQ-028 The final clear write SHALL pulse clear_done in the same cycle, followed by return to IDLE.
REQ-029 clear_req outside IDLE SHALL be ignored; if clear_req and rx_valid arrive in the same cycle in IDLE, clear SHALL win and the byte SHALL be dropped.
REQ-030 All rx_valid in CLEAR SHALL be ignored; fill_value SHALL be sampled once, on CLEAR entry.
REQ-031 wr_addr SHALL never exceed NUM_PIXELS-1, and wr_en SHALL be 0 whenever no write is issued.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, clear_done=0, err_abort=0 and frame_count=0, and SHALL clear the pixel and idle counters.
REQ-033 Reset asserted mid-LOAD or mid-CLEAR SHALL abandon the operation with no done or abort pulse; after release, the first accepted write SHALL require a new header or clear_req.

Verification (NUM_PIXELS=4, TIMEOUT_CYC=16)
REQ-034 Bytes AA 55 10 20 30 40 -> writes (0,10) (1,20) (2,30) (3,40); frame_done on the last write; frame_count=1.
REQ-035 Bytes 12 AA AA 55 01 -> 12 is ignored and the header is accepted; write (0,01); state=LOAD.
REQ-036 Bytes AA 55 10, then 16 idle cycles -> err_abort pulse; state=IDLE; frame_count unchanged.
REQ-037 Bytes AA 55 10 then 20 with rx_ferr=1 -> only (0,10) is written; err_abort pulse; next AA 55 restarts at address 0.
REQ-038 clear_req with fill_value=0x3C, plus rx_valid in the same cycle -> writes (0..3, 3C) on 4 consecutive cycles; clear_done on the 4th; the byte is dropped.
REQ-039 rst_n pulsed low during the 3rd load write, then AA 55 77 -> write (0,77); frame_count=0.

Source files
------------

// File: rtl/frame_load_ctrl.sv
// frame_load_ctrl: receives a framed pixel stream over UART (header AA 55
// followed by NUM_PIXELS bytes) and writes it into a frame-buffer BRAM. It can
// also fill the whole buffer with a constant value on request.
//
// Ports
//   clk, rst_n              : system clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ferr: received byte, one-cycle valid, stop-bit error
//   clear_req, fill_value   : one-cycle fill request and the fill byte
//   wr_en/wr_addr/wr_data   : BRAM write port (registered)
//   busy                    : high while in HDR, LOAD or CLEAR
//   frame_done, clear_done  : one-cycle pulses on the final write of a frame / fill
//   err_abort               : one-cycle pulse when a header or load is abandoned
//   frame_count             : completed frames, wraps at 256
//   state                   : debug state, IDLE=0 HDR=1 LOAD=2 CLEAR=3
module frame_load_ctrl #(
  parameter int unsigned NUM_PIXELS  = 307200,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              clear_req,
  input  logic [7:0]        fill_value,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              clear_done,
  output logic              err_abort,
  output logic [7:0]        frame_count,
  output logic [1:0]        state
);

  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]        SYNC0     = 8'hAA;
  localparam logic [7:0]        SYNC1     = 8'h55;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pix;
  logic [IDLE_W-1:0]   r_idle;
  logic [7:0]          r_fill;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_clear_done;
  logic                r_err_abort;
  logic [7:0]          r_frame_count;

  logic w_byte_ok;
  logic w_timeout;

  assign w_byte_ok = rx_valid & ~rx_ferr;
  // Last silent cycle of the allowed window: abort on this edge.
  assign w_timeout = ~rx_valid & (r_idle == LAST_IDLE);

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pix         <= '0;
      r_idle        <= '0;
      r_fill        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_clear_done  <= 1'b0;
      r_err_abort   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_clear_done <= 1'b0;
      r_err_abort  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_idle <= '0;
          // A fill request takes priority over a byte arriving in the same cycle.
          if (clear_req) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_pix   <= '0;
            r_fill  <= fill_value;
          end else if (w_byte_ok && (rx_data == SYNC0)) begin
            r_state <= ST_HDR;
            r_busy  <= 1'b1;
          end
        end

        ST_HDR: begin
          if (rx_valid) begin
            r_idle <= '0;
            if (!rx_ferr && (rx_data == SYNC1)) begin
              r_state <= ST_LOAD;
              r_pix   <= '0;
            end else if (!rx_ferr && (rx_data == SYNC0)) begin
              r_state <= ST_HDR;
            end else begin
              // Bad header byte: silently resynchronise, not an abort.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_err_abort <= 1'b1;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_idle      <= '0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end

        ST_LOAD: begin
          if (rx_valid) begin
            r_idle <= '0;
            if (rx_ferr) begin
              r_err_abort <= 1'b1;
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_pix;
              r_wr_data <= rx_data;
              if (r_pix == LAST_PIX) begin
                r_frame_done  <= 1'b1;
                r_frame_count <= r_frame_count + 8'd1;
                r_state       <= ST_IDLE;
                r_busy        <= 1'b0;
                r_pix         <= '0;
              end else begin
                r_pix <= r_pix + 1'b1;
              end
            end
          end else if (w_timeout) begin
            r_err_abort <= 1'b1;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_idle      <= '0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end

        ST_CLEAR: begin
          // One fill write per cycle; received bytes are ignored here.
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_pix;
          r_wr_data <= r_fill;
          if (r_pix == LAST_PIX) begin
            r_clear_done <= 1'b1;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_pix        <= '0;
          end else begin
            r_pix <= r_pix + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign clear_done  = r_clear_done;
  assign err_abort   = r_err_abort;
  assign frame_count = r_frame_count;
  assign state       = r_state;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Self-checking bench for frame_load_ctrl with NUM_PIXELS=4, TIMEOUT_CYC=16.
module tb_frame_load_ctrl;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 19;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  logic          clear_req;
  logic [7:0]    fill_value;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic          clear_done;
  logic          err_abort;
  logic [7:0]    frame_count;
  logic [1:0]    state;

  frame_load_ctrl #(
    .NUM_PIXELS (NP),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .clear_req  (clear_req),
    .fill_value (fill_value),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .clear_done (clear_done),
    .err_abort  (err_abort),
    .frame_count(frame_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          fd;
    logic          cd;
  } wr_t;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    int         gap;
  } stim_t;

  wr_t   wq[$];     // observed writes
  wr_t   eq[$];     // model-predicted writes
  int    vcyc[$];   // cycle at which each driven byte is sampled
  stim_t st[$];
  wr_t   mon_w;
  int    cycle_cnt = 0;
  int    abort_cnt = 0;
  int    stray_cnt = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    exp_fc = 0;
  int    exp_abort = 0;

  always @(posedge clk) cycle_cnt = cycle_cnt + 1;

  // Write / pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      mon_w.cyc  = 32'(cycle_cnt);
      mon_w.addr = wr_addr;
      mon_w.data = wr_data;
      mon_w.fd   = frame_done;
      mon_w.cd   = clear_done;
      wq.push_back(mon_w);
    end
    if (err_abort) abort_cnt = abort_cnt + 1;
    if ((frame_done || clear_done) && !wr_en) stray_cnt = stray_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic fe, input int gap);
    rx_data  = d;
    rx_ferr  = fe;
    rx_valid = 1'b1;
    vcyc.push_back(cycle_cnt + 1);
    cyc();
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic clr_mon();
    wq.delete();
    vcyc.delete();
    abort_cnt = 0;
  endtask

  // Reference model: walks the byte stream at protocol level.
  function automatic void model_run(input int fc_in, output int fc_out);
    int   mode;   // 0 waiting for AA, 1 header seen, 2 loading
    int   pix;
    wr_t  w;
    mode = 0; pix = 0; fc_out = fc_in; exp_abort = 0;
    eq.delete();
    foreach (st[i]) begin
      if (mode == 0) begin
        if (st[i].d == 8'hAA && !st[i].fe) mode = 1;
      end else if (mode == 1) begin
        if (st[i].fe) mode = 0;
        else if (st[i].d == 8'h55) begin mode = 2; pix = 0; end
        else if (st[i].d != 8'hAA) mode = 0;
      end else begin
        if (st[i].fe) begin exp_abort++; mode = 0; end
        else begin
          w = '0;
          w.addr = AW'(pix);
          w.data = st[i].d;
          w.fd   = (pix == NP - 1);
          eq.push_back(w);
          if (pix == NP - 1) begin fc_out = (fc_out + 1) % 256; mode = 0; end
          else pix++;
        end
      end
      if (mode != 0 && st[i].gap >= TO) begin exp_abort++; mode = 0; end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_ferr = 1'b0;
    clear_req = 1'b0; fill_value = 8'h00;
    repeat (3) cyc();
    n_chk++; if ({wr_en, busy, frame_done, clear_done, err_abort} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000", {wr_en, busy, frame_done, clear_done, err_abort});
    else n_pass++;
    n_chk++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %0h required 0", wr_addr); else n_pass++;
    n_chk++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %0h required 0", wr_data); else n_pass++;
    n_chk++; if (frame_count !== 8'd0) $display("FAIL reset_frame_count: got %0d required 0", frame_count); else n_pass++;
    n_chk++; if (state !== 2'd0) $display("FAIL reset_state: got %0d required 0", state); else n_pass++;
    rst_n = 1'b1;
    cyc();
    exp_fc = 0;
  endtask

  task automatic test_frame();
    logic [7:0] exp_d[4];
    exp_d = '{8'h10, 8'h20, 8'h30, 8'h40};
    clr_mon();
    send(8'hAA, 1'b0, 0); send(8'h55, 1'b0, 0);
    send(8'h10, 1'b0, 0); send(8'h20, 1'b0, 0); send(8'h30, 1'b0, 0); send(8'h40, 1'b0, 2);
    exp_fc = 1;
    n_chk++; if (wq.size() != 4) $display("FAIL frame_nwrites: got %0d required 4", wq.size()); else n_pass++;
    for (int k = 0; k < 4 && k < wq.size(); k++) begin
      n_chk++;
      if (wq[k].addr !== AW'(k) || wq[k].data !== exp_d[k] || wq[k].fd !== (k == 3) || wq[k].cd !== 1'b0)
        $display("FAIL frame_write%0d: got (%0h,%0h,fd=%b) required (%0h,%0h,fd=%b)",
                 k, wq[k].addr, wq[k].data, wq[k].fd, k, exp_d[k], (k == 3));
      else n_pass++;
      n_chk++;
      if (wq[k].cyc !== 32'(vcyc[k+2]))
        $display("FAIL frame_latency%0d: write at cycle %0d required %0d", k, wq[k].cyc, vcyc[k+2]);
      else n_pass++;
    end
    n_chk++; if (frame_count !== 8'(exp_fc)) $display("FAIL frame_count: got %0d required %0d", frame_count, exp_fc); else n_pass++;
    n_chk++; if (state !== 2'd0 || busy !== 1'b0) $display("FAIL frame_end_state: got state %0d busy %b required 0 0", state, busy); else n_pass++;
    n_chk++; if (abort_cnt != 0) $display("FAIL frame_abort: got %0d aborts required 0", abort_cnt); else n_pass++;
  endtask

  task automatic test_hdr_resync();
    clr_mon();
    send(8'h12, 1'b0, 0); send(8'hAA, 1'b0, 0); send(8'hAA, 1'b0, 0); send(8'h55, 1'b0, 0);
    send(8'h01, 1'b0, 0);
    n_chk++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 8'h01)
      $display("FAIL resync_write: got en=%b (%0h,%0h) required en=1 (0,01)", wr_en, wr_addr, wr_data);
    else n_pass++;
    n_chk++; if (state !== 2'd2 || busy !== 1'b1) $display("FAIL resync_state: got %0d busy %b required 2 1", state, busy); else n_pass++;
    repeat (TO + 4) cyc();
    n_chk++; if (wq.size() != 1) $display("FAIL resync_nwrites: got %0d required 1", wq.size()); else n_pass++;
    n_chk++; if (abort_cnt != 1 || state !== 2'd0) $display("FAIL resync_timeout: got aborts %0d state %0d required 1 0", abort_cnt, state); else n_pass++;
  endtask

  task automatic test_timeout();
    clr_mon();
    send(8'hAA, 1'b0, 0); send(8'h55, 1'b0, 0);
    send(8'h10, 1'b0, TO - 1);
    n_chk++; if (state !== 2'd2 || abort_cnt != 0) $display("FAIL timeout_early1: got state %0d aborts %0d required 2 0", state, abort_cnt); else n_pass++;
    send(8'h20, 1'b0, TO - 1);
    n_chk++; if (state !== 2'd2 || err_abort !== 1'b0) $display("FAIL timeout_early2: got state %0d abort %b required 2 0", state, err_abort); else n_pass++;
    cyc();
    n_chk++; if (err_abort !== 1'b1 || state !== 2'd0) $display("FAIL timeout_fire: got abort %b state %0d required 1 0", err_abort, state); else n_pass++;
    cyc();
    n_chk++; if (err_abort !== 1'b0) $display("FAIL timeout_pulse: got abort %b required 0", err_abort); else n_pass++;
    n_chk++; if (frame_count !== 8'(exp_fc)) $display("FAIL timeout_count: got %0d required %0d", frame_count, exp_fc); else n_pass++;
    n_chk++; if (wq.size() != 2 || abort_cnt != 1) $display("FAIL timeout_totals: got writes %0d aborts %0d required 2 1", wq.size(), abort_cnt); else n_pass++;
  endtask

  task automatic test_ferr();
    clr_mon();
    send(8'hAA, 1'b0, 0); send(8'h55, 1'b0, 0); send(8'h10, 1'b0, 0);
    send(8'h20, 1'b1, 2);
    n_chk++; if (abort_cnt != 1 || state !== 2'd0) $display("FAIL ferr_abort: got aborts %0d state %0d required 1 0", abort_cnt, state); else n_pass++;
    n_chk++;
    if (wq.size() != 1) $display("FAIL ferr_nwrites: got %0d required 1", wq.size());
    else if (wq[0].addr !== '0 || wq[0].data !== 8'h10) $display("FAIL ferr_write: got (%0h,%0h) required (0,10)", wq[0].addr, wq[0].data);
    else n_pass++;
    n_chk++; if (frame_count !== 8'(exp_fc)) $display("FAIL ferr_count: got %0d required %0d", frame_count, exp_fc); else n_pass++;
    send(8'hAA, 1'b0, 0); send(8'h55, 1'b0, 0); send(8'h5A, 1'b0, 0);
    n_chk++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 8'h5A)
      $display("FAIL ferr_restart: got en=%b (%0h,%0h) required en=1 (0,5a)", wr_en, wr_addr, wr_data);
    else n_pass++;
    repeat (TO + 4) cyc();
    n_chk++; if (abort_cnt != 2) $display("FAIL ferr_final_aborts: got %0d required 2", abort_cnt); else n_pass++;
  endtask

  task automatic test_clear();
    int c0;
    clr_mon();
    clear_req = 1'b1; fill_value = 8'h3C; rx_valid = 1'b1; rx_data = 8'hAA; rx_ferr = 1'b0;
    c0 = cycle_cnt + 1;
    cyc();
    clear_req = 1'b0; fill_value = 8'hC3; rx_valid = 1'b1; rx_data = 8'hAA;
    n_chk++; if (state !== 2'd3 || busy !== 1'b1) $display("FAIL clear_enter: got state %0d busy %b required 3 1", state, busy); else n_pass++;
    cyc();
    rx_data = 8'h55; clear_req = 1'b1;
    cyc();
    rx_valid = 1'b0; clear_req = 1'b0;
    repeat (6) cyc();
    n_chk++; if (wq.size() != 4) $display("FAIL clear_nwrites: got %0d required 4", wq.size()); else n_pass++;
    for (int k = 0; k < 4 && k < wq.size(); k++) begin
      n_chk++;
      if (wq[k].addr !== AW'(k) || wq[k].data !== 8'h3C || wq[k].cd !== (k == 3) || wq[k].fd !== 1'b0)
        $display("FAIL clear_write%0d: got (%0h,%0h,cd=%b) required (%0h,3c,cd=%b)", k, wq[k].addr, wq[k].data, wq[k].cd, k, (k == 3));
      else n_pass++;
      n_chk++;
      if (wq[k].cyc !== wq[0].cyc + 32'(k))
        $display("FAIL clear_gap%0d: write at cycle %0d required %0d", k, wq[k].cyc, wq[0].cyc + 32'(k));
      else n_pass++;
    end
    n_chk++;
    if (wq.size() > 0 && wq[0].cyc > 32'(c0 + 1)) $display("FAIL clear_start: first write at cycle %0d required by %0d", wq[0].cyc, c0 + 1);
    else n_pass++;
    n_chk++; if (state !== 2'd0 || busy !== 1'b0 || abort_cnt != 0) $display("FAIL clear_end: got state %0d busy %b aborts %0d required 0 0 0", state, busy, abort_cnt); else n_pass++;
  endtask

  task automatic test_random();
    stim_t s;
    int    r;
    int    fc_new;
    clr_mon();
    st.delete();
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 9));
      s.d  = (r < 3) ? 8'hAA : (r < 6) ? 8'h55 : 8'($urandom);
      s.fe = ($urandom_range(0, 11) == 0);
      r = int'($urandom_range(0, 19));
      s.gap = (r < 16) ? (r % 4) : (r < 18) ? int'(TO + $urandom_range(0, 3)) : int'(TO - 1);
      if (i == 249) s.gap = TO + 4;
      st.push_back(s);
    end
    foreach (st[i]) send(st[i].d, st[i].fe, st[i].gap);
    model_run(exp_fc, fc_new);
    exp_fc = fc_new;
    n_chk++; if (wq.size() != eq.size()) $display("FAIL rand_nwrites: got %0d required %0d", wq.size(), eq.size()); else n_pass++;
    for (int k = 0; k < eq.size() && k < wq.size(); k++) begin
      n_chk++;
      if (wq[k].addr !== eq[k].addr || wq[k].data !== eq[k].data || wq[k].fd !== eq[k].fd || wq[k].cd !== 1'b0)
        $display("FAIL rand_write%0d: got (%0h,%0h,fd=%b) required (%0h,%0h,fd=%b)",
                 k, wq[k].addr, wq[k].data, wq[k].fd, eq[k].addr, eq[k].data, eq[k].fd);
      else n_pass++;
    end
    n_chk++; if (abort_cnt != exp_abort) $display("FAIL rand_aborts: got %0d required %0d", abort_cnt, exp_abort); else n_pass++;
    n_chk++; if (frame_count !== 8'(exp_fc)) $display("FAIL rand_count: got %0d required %0d", frame_count, exp_fc); else n_pass++;
    n_chk++; if (stray_cnt != 0) $display("FAIL stray_done: got %0d done pulses without a write required 0", stray_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    clr_mon();
    send(8'hAA, 1'b0, 0); send(8'h55, 1'b0, 0); send(8'h10, 1'b0, 0); send(8'h20, 1'b0, 0);
    rx_data = 8'h30; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (wr_en !== 1'b0 || state !== 2'd0 || busy !== 1'b0 || frame_done !== 1'b0 || err_abort !== 1'b0 || frame_count !== 8'd0)
      $display("FAIL midreset_outputs: got en=%b st=%0d busy=%b fd=%b ab=%b fc=%0d required all 0",
               wr_en, state, busy, frame_done, err_abort, frame_count);
    else n_pass++;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    exp_fc = 0;
    clr_mon();
    send(8'h55, 1'b0, 0); send(8'h01, 1'b0, 2);
    n_chk++; if (wq.size() != 0) $display("FAIL midreset_nohdr: got %0d writes required 0", wq.size()); else n_pass++;
    send(8'hAA, 1'b0, 0); send(8'h55, 1'b0, 0); send(8'h77, 1'b0, 0);
    n_chk++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 8'h77)
      $display("FAIL midreset_write: got en=%b (%0h,%0h) required en=1 (0,77)", wr_en, wr_addr, wr_data);
    else n_pass++;
    n_chk++; if (frame_count !== 8'd0) $display("FAIL midreset_count: got %0d required 0", frame_count); else n_pass++;
    repeat (TO + 4) cyc();
    n_chk++; if (wq.size() != 1 || abort_cnt != 1) $display("FAIL midreset_totals: got writes %0d aborts %0d required 1 1", wq.size(), abort_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hdr_resync();
    test_timeout();
    test_ferr();
    test_clear();
    test_random();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
